// File: rtl/vga_fx_pkg.sv
// Shared VGA effect definitions: channel state encoding, visible-area limits
// and a modular subtract used for vertical wrap-around.
package vga_fx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FIRE = 1'b1
  } ch_state_t;

  localparam logic [10:0] H_ACTIVE = 11'd640;
  localparam logic [10:0] V_ACTIVE = 11'd480;

  // (a - b) mod modulus for a, b in 0..modulus-1; one add-back suffices.
  function automatic logic [10:0] wrap_sub(input logic [10:0] a,
                                           input logic [10:0] b,
                                           input logic [10:0] modulus);
    logic [11:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[11]) diff = diff + {1'b0, modulus};
    return diff[10:0];
  endfunction

endpackage

// File: rtl/projectile_channel.sv
// One projectile channel: IDLE/FIRE lifetime FSM with frame countdown, plus the
// wrap-aware sprite hit test and sprite-local ROM address for the current pixel.
module projectile_channel
  import vga_fx_pkg::*;
#(
  parameter int SPR_W    = 200,
  parameter int SPR_H    = 112,
  parameter int SCREEN_H = 480,
  parameter int DURATION = 100,
  parameter int BLINK    = 1,
  parameter int ADDR_W   = $clog2(SPR_W * SPR_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              fire,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  output logic              active,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);

  ch_state_t   state;
  logic [9:0]  remain;
  logic [10:0] top;
  logic [10:0] row;
  logic [10:0] col;
  logic        visible;
  logic        v_in;
  logic        h_in;

  // A trigger always wins over a coincident frame tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      remain <= '0;
      active <= 1'b0;
    end else if (fire) begin
      state  <= FIRE;
      remain <= 10'(DURATION);
      active <= 1'b1;
    end else if (state == FIRE && frame_tick) begin
      if (remain == '0) begin
        state  <= IDLE;
        active <= 1'b0;
      end else begin
        remain <= remain - 10'd1;
      end
    end
  end

  always_comb begin
    top     = wrap_sub({1'b0, pos_y}, 11'(SPR_H / 2), 11'(SCREEN_H));
    row     = wrap_sub({1'b0, v_cnt}, top, 11'(SCREEN_H));
    col     = {1'b0, h_cnt} - {1'b0, pos_x};
    visible = (state == FIRE) && ((BLINK == 0) || remain[0]);
    v_in    = ({1'b0, v_cnt} < 11'(SCREEN_H)) && ({1'b0, v_cnt} < V_ACTIVE) &&
              (row < 11'(SPR_H));
    h_in    = ({1'b0, h_cnt} < H_ACTIVE) && (h_cnt >= pos_x) &&
              (col < 11'(SPR_W));
    hit     = visible && v_in && h_in;
    addr    = hit ? ADDR_W'(32'(row) * 32'(SPR_W) + 32'(col)) : '0;
  end

endmodule

// File: rtl/mem_addr_gen_projectile.sv
// Multi-channel projectile sprite address generator: per-channel hit tests,
// lowest-index priority select and a one-cycle registered output stage.
module mem_addr_gen_projectile
  import vga_fx_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int SPR_W    = 200,
  parameter int SPR_H    = 112,
  parameter int SCREEN_H = 480,
  parameter int DURATION = 100,
  parameter int BLINK    = 1,
  parameter int ADDR_W   = $clog2(SPR_W * SPR_H),
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic [N_CH-1:0]    fire,
  input  logic [10*N_CH-1:0] pos_x,
  input  logic [10*N_CH-1:0] pos_y,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic               pixel_hit,
  output logic [CH_W-1:0]    hit_ch,
  output logic [N_CH-1:0]    active
);

  logic [N_CH-1:0]   ch_hit;
  logic [ADDR_W-1:0] ch_addr [N_CH];
  logic              sel_hit;
  logic [CH_W-1:0]   sel_ch;
  logic [ADDR_W-1:0] sel_addr;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    projectile_channel #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .SCREEN_H(SCREEN_H),
      .DURATION(DURATION),
      .BLINK   (BLINK),
      .ADDR_W  (ADDR_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_tick(frame_tick),
      .fire      (fire[g]),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .pos_x     (pos_x[10*g +: 10]),
      .pos_y     (pos_y[10*g +: 10]),
      .active    (active[g]),
      .hit       (ch_hit[g]),
      .addr      (ch_addr[g])
    );
  end

  // Scan from the top index down so the lowest hitting channel overwrites last.
  always_comb begin
    sel_hit  = 1'b0;
    sel_ch   = '0;
    sel_addr = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (ch_hit[i-1]) begin
        sel_hit  = 1'b1;
        sel_ch   = CH_W'(i - 1);
        sel_addr = ch_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_addr <= '0;
      pixel_hit  <= 1'b0;
      hit_ch     <= '0;
    end else begin
      pixel_addr <= sel_addr;
      pixel_hit  <= sel_hit;
      hit_ch     <= sel_ch;
    end
  end

endmodule

// File: tb/tb_mem_addr_gen_projectile.sv
// Directed bench: a blinking 4-channel instance (DURATION=4) and a solid
// 2-channel instance (DURATION=60) driven from shared pixel/frame timing.
module tb_mem_addr_gen_projectile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n_b, frame_tick;
  logic [9:0]  h_cnt, v_cnt;

  logic [3:0]  fire_a;
  logic [39:0] pos_x_a, pos_y_a;
  logic [14:0] addr_a;
  logic        hit_a;
  logic [1:0]  ch_a;
  logic [3:0]  act_a;

  logic [1:0]  fire_b;
  logic [19:0] pos_x_b, pos_y_b;
  logic [14:0] addr_b;
  logic        hit_b;
  logic [0:0]  ch_b;
  logic [1:0]  act_b;

  int checks = 0;
  int errors = 0;
  logic any_hit;

  mem_addr_gen_projectile #(
    .N_CH(4), .SPR_W(200), .SPR_H(112), .SCREEN_H(480),
    .DURATION(4), .BLINK(1), .ADDR_W(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .fire(fire_a),
    .pos_x(pos_x_a), .pos_y(pos_y_a),
    .pixel_addr(addr_a), .pixel_hit(hit_a), .hit_ch(ch_a), .active(act_a)
  );

  mem_addr_gen_projectile #(
    .N_CH(2), .SPR_W(200), .SPR_H(112), .SCREEN_H(480),
    .DURATION(60), .BLINK(0), .ADDR_W(15)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .frame_tick(frame_tick),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .fire(fire_b),
    .pos_x(pos_x_b), .pos_y(pos_y_b),
    .pixel_addr(addr_b), .pixel_hit(hit_b), .hit_ch(ch_b), .active(act_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic probe(input int h, input int v);
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    cyc();
  endtask

  task automatic chk_a(input string tag, input logic hit, input int addr, input int ch);
    chk({tag, ".hit"},  32'(hit_a),  32'(hit));
    chk({tag, ".addr"}, 32'(addr_a), 32'(addr));
    chk({tag, ".ch"},   32'(ch_a),   32'(ch));
  endtask

  task automatic chk_b(input string tag, input logic hit, input int addr, input int ch);
    chk({tag, ".hit"},  32'(hit_b),  32'(hit));
    chk({tag, ".addr"}, 32'(addr_b), 32'(addr));
    chk({tag, ".ch"},   32'(ch_b),   32'(ch));
  endtask

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0; frame_tick = 1'b0;
    h_cnt = '0; v_cnt = '0; fire_a = '0; fire_b = '0;
    pos_x_a = {10'd0, 10'd50,  10'd300, 10'd120};
    pos_y_a = {10'd0, 10'd300, 10'd20,  10'd240};
    pos_x_b = {10'd500, 10'd0};
    pos_y_b = {10'd240, 10'd56};

    // Reset and idle frame scan
    repeat (3) cyc();
    chk_a("rst_a", 1'b0, 0, 0);
    chk_b("rst_b", 1'b0, 0, 0);
    chk("rst_act_a", 32'(act_a), 32'd0);
    rst_n = 1'b1; rst_n_b = 1'b1;
    any_hit = 1'b0;
    for (int v = 0; v < 480; v += 40)
      for (int h = 0; h < 640; h += 40) begin
        probe(h, v);
        any_hit = any_hit | hit_a | hit_b;
      end
    tick();
    chk("idle_any_hit", 32'(any_hit), 32'd0);
    chk("idle_act_a", 32'(act_a), 32'd0);
    chk("idle_act_b", 32'(act_b), 32'd0);

    // Single fire on channel 0, blink visible at remain 3 and 1
    fire_a = 4'b0001; cyc(); fire_a = '0;
    chk("fire_act", 32'(act_a), 32'b0001);
    probe(120, 184); chk_a("r4", 1'b0, 0, 0);
    tick();
    probe(120, 184); chk_a("r3_origin", 1'b1, 0, 0);
    probe(319, 295); chk_a("r3_last", 1'b1, 22399, 0);
    probe(320, 295); chk_a("r3_col200", 1'b0, 0, 0);
    probe(319, 296); chk_a("r3_row112", 1'b0, 0, 0);
    probe(119, 184); chk_a("r3_left", 1'b0, 0, 0);
    tick();
    probe(120, 184); chk_a("r2", 1'b0, 0, 0);
    tick();
    probe(120, 184); chk_a("r1", 1'b1, 0, 0);
    tick();
    probe(120, 184); chk_a("r0", 1'b0, 0, 0);
    chk("r0_act", 32'(act_a), 32'b0001);
    tick();
    chk("expire_act", 32'(act_a), 32'b0000);

    // Vertical wrap on channel 1: pos_y=20 -> top=444
    fire_a = 4'b0010; cyc(); fire_a = '0;
    tick();
    probe(300, 444); chk_a("wrap_top", 1'b1, 0, 1);
    probe(300, 0);   chk_a("wrap_v0", 1'b1, 7200, 1);
    probe(305, 75);  chk_a("wrap_v75", 1'b1, 22205, 1);
    probe(300, 76);  chk_a("wrap_v76", 1'b0, 0, 0);
    probe(300, 100); chk_a("wrap_v100", 1'b0, 0, 0);
    probe(300, 480); chk_a("wrap_v480", 1'b0, 0, 0);

    // Overlap: channels 0 and 2 at (50,300)
    pos_x_a[9:0] = 10'd50;
    pos_y_a[9:0] = 10'd300;
    fire_a = 4'b0101; cyc(); fire_a = '0;
    tick();
    probe(60, 250); chk_a("ovl_both", 1'b1, 1210, 0);
    tick();
    fire_a = 4'b0100; cyc(); fire_a = '0;
    tick(); tick(); tick();
    chk("ovl_act", 32'(act_a), 32'b0100);
    probe(60, 250); chk_a("ovl_ch2", 1'b1, 1210, 2);

    // Retrigger coincident with frame tick at remain 1
    fire_a = 4'b0010; cyc(); fire_a = '0;
    tick(); tick(); tick();
    probe(300, 444); chk_a("rt_r1", 1'b1, 0, 1);
    fire_a = 4'b0010; frame_tick = 1'b1; cyc(); fire_a = '0; frame_tick = 1'b0;
    chk("rt_act", 32'(act_a), 32'b0010);
    probe(300, 444); chk_a("rt_r4", 1'b0, 0, 0);
    tick();
    probe(300, 444); chk_a("rt_r3", 1'b1, 0, 1);
    tick(); tick(); tick();
    chk("rt_r0_act", 32'(act_a), 32'b0010);
    tick();
    chk("rt_expire_act", 32'(act_a), 32'b0000);

    // Solid instance: h limit, then reset mid-effect at remain 50
    fire_b = 2'b01; cyc(); fire_b = '0;
    probe(0, 0); chk_b("b_origin", 1'b1, 0, 0);
    fire_b = 2'b10; cyc(); fire_b = '0;
    probe(639, 200); chk_b("b_h639", 1'b1, 3339, 1);
    probe(640, 200); chk_b("b_h640", 1'b0, 0, 0);
    repeat (10) tick();
    probe(199, 111); chk_b("b_r50_last", 1'b1, 22399, 0);
    chk("b_act", 32'(act_b), 32'b11);
    rst_n_b = 1'b0; cyc();
    chk_b("b_rst", 1'b0, 0, 0);
    chk("b_rst_act", 32'(act_b), 32'b00);
    rst_n_b = 1'b1;
    probe(199, 111); chk_b("b_after_rst", 1'b0, 0, 0);
    chk("b_after_act", 32'(act_b), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
